// File: rtl/serv_rvfi_trace.sv
// RVFI retirement tracer: queues one record per retirement and streams it out W bits per beat, LSB first.
// Define SERV_TRACE_WDATA_EN to append rd_wdata as a fourth record word.
module serv_rvfi_trace #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_rvfi_valid,
  input  logic [63:0]  i_rvfi_order,
  input  logic [31:0]  i_rvfi_insn,
  input  logic         i_rvfi_trap,
  input  logic [4:0]   i_rvfi_rd_addr,
  input  logic [31:0]  i_rvfi_rd_wdata,
  input  logic [31:0]  i_rvfi_pc_rdata,
  output logic         o_tr_valid,
  output logic [W-1:0] o_tr_data,
  output logic         o_tr_last,
  input  logic         i_tr_ready,
  output logic         o_overflow,
  output logic [7:0]   o_drop_cnt,
  input  logic         i_clr
);
`ifdef SERV_TRACE_WDATA_EN
  localparam int WORDS = 4;
`else
  localparam int WORDS = 3;
`endif
  localparam int REC_W = WORDS * 32;
  localparam int BEATS = REC_W / W;
  localparam int BW    = $clog2(BEATS);
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state;
  logic [REC_W-1:0] mem [DEPTH];
  logic [REC_W-1:0] rec_in;
  logic [31:0]      w0;
  logic [PW-1:0]    wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0]    count;
  logic [BW-1:0]    beat, beat_nxt;
  logic             full, push, drop, hs, pop;
  logic             unused_bits;

  assign w0 = {8'hA5, i_rvfi_trap, 2'b00, i_rvfi_rd_addr, i_rvfi_order[15:0]};
`ifdef SERV_TRACE_WDATA_EN
  assign rec_in      = {i_rvfi_rd_wdata, i_rvfi_insn, i_rvfi_pc_rdata, w0};
  assign unused_bits = ^i_rvfi_order[63:16];
`else
  assign rec_in      = {i_rvfi_insn, i_rvfi_pc_rdata, w0};
  assign unused_bits = ^{i_rvfi_order[63:16], i_rvfi_rd_wdata};
`endif

  // Full is judged on current occupancy, so a same-cycle pop never frees a slot for the push.
  assign full     = (count == FULL_CNT);
  assign push     = i_rvfi_valid & ~full;
  assign drop     = i_rvfi_valid & full;
  assign hs       = (state == SEND) & o_tr_valid & i_tr_ready;
  assign pop      = hs & (beat == LAST_BEAT);
  assign rd_nxt   = rd_ptr + PW'(1);
  assign beat_nxt = beat + BW'(1);

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= rec_in;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_nxt;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // The head record stays resident while it is being sent; beat indexes into it directly.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      beat       <= '0;
      o_tr_valid <= 1'b0;
      o_tr_last  <= 1'b0;
      o_tr_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            state      <= SEND;
            beat       <= '0;
            o_tr_valid <= 1'b1;
            o_tr_data  <= mem[rd_ptr][W-1:0];
            o_tr_last  <= (LAST_BEAT == '0);
          end
        end
        SEND: begin
          if (hs) begin
            if (beat == LAST_BEAT) begin
              if (count > CW'(1)) begin
                beat      <= '0;
                o_tr_data <= mem[rd_nxt][W-1:0];
                o_tr_last <= (LAST_BEAT == '0);
              end else begin
                state      <= IDLE;
                beat       <= '0;
                o_tr_valid <= 1'b0;
                o_tr_last  <= 1'b0;
              end
            end else begin
              beat      <= beat_nxt;
              o_tr_data <= mem[rd_ptr][int'(beat_nxt)*W +: W];
              o_tr_last <= (beat_nxt == LAST_BEAT);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_overflow <= 1'b0;
      o_drop_cnt <= '0;
    end else if (i_clr) begin
      o_overflow <= 1'b0;
      o_drop_cnt <= '0;
    end else if (drop) begin
      o_overflow <= 1'b1;
      if (o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_serv_rvfi_trace.sv
// Directed bench for serv_rvfi_trace at W=8, DEPTH=4; beat count follows SERV_TRACE_WDATA_EN.
module tb_serv_rvfi_trace;
`ifdef SERV_TRACE_WDATA_EN
  localparam int BEATS = 16;
`else
  localparam int BEATS = 12;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_rvfi_valid;
  logic [63:0] i_rvfi_order;
  logic [31:0] i_rvfi_insn;
  logic        i_rvfi_trap;
  logic [4:0]  i_rvfi_rd_addr;
  logic [31:0] i_rvfi_rd_wdata;
  logic [31:0] i_rvfi_pc_rdata;
  logic        o_tr_valid;
  logic [7:0]  o_tr_data;
  logic        o_tr_last;
  logic        i_tr_ready;
  logic        o_overflow;
  logic [7:0]  o_drop_cnt;
  logic        i_clr;

  int checks = 0;
  int errors = 0;
  int n;
  logic [7:0] held;
  logic [7:0] tbl_a [16] = '{8'h05, 8'h00, 8'h01, 8'hA5, 8'h00, 8'h01, 8'h00, 8'h00,
                             8'h93, 8'h00, 8'h50, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};

  serv_rvfi_trace #(.W(8), .DEPTH(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rvfi_valid(i_rvfi_valid),
    .i_rvfi_order(i_rvfi_order), .i_rvfi_insn(i_rvfi_insn), .i_rvfi_trap(i_rvfi_trap),
    .i_rvfi_rd_addr(i_rvfi_rd_addr), .i_rvfi_rd_wdata(i_rvfi_rd_wdata),
    .i_rvfi_pc_rdata(i_rvfi_pc_rdata), .o_tr_valid(o_tr_valid), .o_tr_data(o_tr_data),
    .o_tr_last(o_tr_last), .i_tr_ready(i_tr_ready), .o_overflow(o_overflow),
    .o_drop_cnt(o_drop_cnt), .i_clr(i_clr)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Record k: order=k, trap=k[0], rd=k[4:0], pc=0x200+4k, insn=0x13+(k<<7), wdata=0x11*k.
  function automatic logic [7:0] rec_beat(input int k, input int b);
    logic [127:0] rec;
    logic [31:0]  pc, insn, wd;
    pc   = 32'h200 + 32'(4 * k);
    insn = 32'h13 + 32'(k << 7);
    wd   = 32'(32'h11 * k);
    rec  = {wd, insn, pc, 8'hA5, k[0], 2'b00, 5'(k), 16'(k)};
    return rec[b*8 +: 8];
  endfunction

  task automatic put(input int k);
    i_rvfi_valid    = 1'b1;
    i_rvfi_order    = 64'(k);
    i_rvfi_trap     = k[0];
    i_rvfi_rd_addr  = 5'(k);
    i_rvfi_pc_rdata = 32'h200 + 32'(4 * k);
    i_rvfi_insn     = 32'h13 + 32'(k << 7);
    i_rvfi_rd_wdata = 32'(32'h11 * k);
  endtask

  initial begin
    i_rst_n = 1'b0; i_rvfi_valid = 1'b0; i_rvfi_order = '0; i_rvfi_insn = '0;
    i_rvfi_trap = 1'b0; i_rvfi_rd_addr = '0; i_rvfi_rd_wdata = '0; i_rvfi_pc_rdata = '0;
    i_tr_ready = 1'b1; i_clr = 1'b0;
    repeat (3) tick;
    chk("rst_valid", o_tr_valid, 0);
    chk("rst_last", o_tr_last, 0);
    chk("rst_data", o_tr_data, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_drop", o_drop_cnt, 0);
    i_rst_n = 1'b1;
    tick;

    // Single retirement, hand-computed beats
    i_rvfi_valid = 1'b1; i_rvfi_order = 64'd5; i_rvfi_pc_rdata = 32'h100;
    i_rvfi_insn = 32'h00500093; i_rvfi_rd_addr = 5'd1; i_rvfi_rd_wdata = 32'd5; i_rvfi_trap = 1'b0;
    tick;
    i_rvfi_valid = 1'b0;
    chk("a_lat1_valid", o_tr_valid, 0);
    tick;
    for (int b = 0; b < BEATS; b++) begin
      chk("a_valid", o_tr_valid, 1);
      chk("a_data", o_tr_data, tbl_a[b]);
      chk("a_last", o_tr_last, (b == BEATS - 1));
      tick;
    end
    chk("a_idle", o_tr_valid, 0);

    // Back-pressure mid-record
    put(6); tick; i_rvfi_valid = 1'b0; tick;
    for (int b = 0; b < BEATS; b++) begin
      chk("b_data", o_tr_data, rec_beat(6, b));
      chk("b_last", o_tr_last, (b == BEATS - 1));
      if (b == 5) begin
        held = o_tr_data;
        i_tr_ready = 1'b0;
        repeat (10) begin
          tick;
          chk("b_stall_valid", o_tr_valid, 1);
          chk("b_stall_data", o_tr_data, held);
          chk("b_stall_last", o_tr_last, 0);
        end
        i_tr_ready = 1'b1;
      end
      tick;
    end
    chk("b_idle", o_tr_valid, 0);

    // Overflow: six retirements into a stalled four-deep FIFO
    i_tr_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin put(10 + i); tick; end
    i_rvfi_valid = 1'b0;
    chk("c_drop", o_drop_cnt, 2);
    chk("c_ovf", o_overflow, 1);
    chk("c_hold_valid", o_tr_valid, 1);
    i_tr_ready = 1'b1;
    for (int r = 0; r < 4; r++)
      for (int b = 0; b < BEATS; b++) begin
        chk("c_valid", o_tr_valid, 1);
        chk("c_data", o_tr_data, rec_beat(10 + r, b));
        chk("c_last", o_tr_last, (b == BEATS - 1));
        tick;
      end
    chk("c_idle", o_tr_valid, 0);
    chk("c_drop_kept", o_drop_cnt, 2);
    i_clr = 1'b1; tick; i_clr = 1'b0;
    chk("c_clr_drop", o_drop_cnt, 0);
    chk("c_clr_ovf", o_overflow, 0);

    // Three queued records stream back to back
    i_tr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin put(20 + i); tick; end
    i_rvfi_valid = 1'b0;
    i_tr_ready = 1'b1;
    for (int r = 0; r < 3; r++)
      for (int b = 0; b < BEATS; b++) begin
        chk("d_valid", o_tr_valid, 1);
        chk("d_data", o_tr_data, rec_beat(20 + r, b));
        tick;
      end
    chk("d_idle", o_tr_valid, 0);

    // Saturating drop counter, then clear beats a same-cycle drop
    i_tr_ready = 1'b0;
    for (int i = 0; i < 304; i++) begin put(30); tick; end
    i_rvfi_valid = 1'b0;
    chk("e_sat", o_drop_cnt, 255);
    chk("e_ovf", o_overflow, 1);
    put(31); i_clr = 1'b1; tick;
    i_rvfi_valid = 1'b0; i_clr = 1'b0;
    chk("e_clr_drop", o_drop_cnt, 0);
    chk("e_clr_ovf", o_overflow, 0);

    // Push while full coinciding with the final-beat pop is still dropped
    i_tr_ready = 1'b1;
    repeat (BEATS - 1) tick;
    chk("e_last_beat", o_tr_last, 1);
    put(32); tick; i_rvfi_valid = 1'b0;
    chk("e_pop_push_drop", o_drop_cnt, 1);
    n = 0;
    for (int c = 0; c < 10 * BEATS; c++) begin
      if (o_tr_valid) n++;
      tick;
    end
    chk("e_drain_beats", n, 3 * BEATS);

    // Reset mid-record
    put(40); tick; i_rvfi_valid = 1'b0; tick;
    repeat (7) tick;
    chk("f_beat7", o_tr_data, rec_beat(40, 7));
    i_rst_n = 1'b0;
    #1;
    chk("f_rst_valid", o_tr_valid, 0);
    chk("f_rst_data", o_tr_data, 0);
    chk("f_rst_last", o_tr_last, 0);
    put(41); tick; tick; i_rvfi_valid = 1'b0;
    i_rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick;
      chk("f_empty", o_tr_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
